// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus request sequencer feeding a UART transmitter: one byte per frame,
// paced by tx_active, with an enforced idle gap and a start-request timeout.
module uart_tx_feeder #(
    parameter int DEPTH         = 16,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout,
    input  logic                     clr_flags,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_active
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic [GW-1:0]   gap_cnt, gap_nx;
    logic [7:0]      data_nx;
    logic            start_nx;
    logic            push, pop, timeout_evt, tmo_hit, gap_done;

    assign full     = (level == (AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign push     = wr_en && !full;
    assign tmo_hit  = (int'(tmo_cnt) >= START_TIMEOUT - 1);
    assign gap_done = (int'(gap_cnt) >= GAP_CYCLES);

    always_comb begin
        state_nx    = state;
        start_nx    = tx_start;
        data_nx     = tx_data;
        tmo_nx      = tmo_cnt;
        gap_nx      = gap_cnt;
        pop         = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                start_nx = 1'b0;
                if (!empty) begin
                    pop      = 1'b1;
                    data_nx  = mem[rd_ptr];
                    start_nx = 1'b1;
                    tmo_nx   = '0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                start_nx = 1'b1;
                if (tx_active) begin
                    start_nx = 1'b0;
                    state_nx = BUSY;
                end else if (tmo_hit) begin
                    // Byte is dropped, not retried; the gap still applies.
                    start_nx    = 1'b0;
                    timeout_evt = 1'b1;
                    gap_nx      = '0;
                    state_nx    = GAP;
                end else begin
                    tmo_nx = tmo_cnt + TW'(1);
                end
            end
            BUSY: begin
                start_nx = 1'b0;
                if (!tx_active) begin
                    gap_nx   = '0;
                    state_nx = GAP;
                end
            end
            GAP: begin
                start_nx = 1'b0;
                if (gap_done) state_nx = IDLE;
                else          gap_nx   = gap_cnt + GW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_start <= start_nx;
            tx_data  <= data_nx;
            tmo_cnt  <= tmo_nx;
            gap_cnt  <= gap_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + (AW + 1)'(1);
            else if (!push && pop) level <= level - (AW + 1)'(1);
            // A new event in the same cycle as clr_flags keeps the flag set.
            overflow <= (overflow && !clr_flags) || (wr_en && full);
            timeout  <= (timeout && !clr_flags) || timeout_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and sequencer sitting directly upstream of the UART top-level transmitter.
- Accepts bytes from the host side into a FIFO.
- Presents one byte at a time on tx_data and requests a frame with a level tx_start.
- Uses the transmitter's TX_active to pace frames, enforcing a minimum idle gap and flagging a transmitter that never starts.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2)
GAP_CYCLES, 2, minimum clk cycles with tx_start low after TX_active falls, before the next request
START_TIMEOUT, 1023, cycles tx_start may stay high without TX_active rising before the byte is dropped

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  host write strobe
wr_data  in  8  host byte
full  out  1  FIFO full (level==DEPTH)
empty  out  1  FIFO empty (level==0)
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: write attempted while full
timeout  out  1  sticky: start request expired
clr_flags  in  1  synchronous clear of overflow and timeout
tx_data  out  8  byte presented to transmitter (drives UART data_in)
tx_start  out  1  frame request (drives UART transmit)
tx_active  in  1  transmitter busy (from UART TX_active)

Behaviour:
- Reset (reset==0, async): FIFO pointers and level = 0, full=0, empty=1, overflow=0, timeout=0, tx_data=8'h00, tx_start=0, FSM=IDLE, gap and timeout counters cleared. Reset mid-frame discards the buffered bytes and the in-flight byte. tx_start drops immediately.
- FIFO:
  - Write accepted when wr_en && !full, with full sampled as the registered value at the start of the cycle.
  - A write while full is rejected, sets overflow, and leaves contents unchanged, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- clr_flags clears overflow/timeout next edge. An overflow or timeout event in the same cycle wins (flag stays 1).
- FSM, all outputs registered:
  - IDLE: if !empty, pop the head into tx_data, set tx_start=1, load the timeout counter, go REQ. Otherwise tx_start=0.
  - REQ: tx_start=1, tx_data stable.
    - If tx_active==1: tx_start=0, go BUSY.
    - Else if the timeout counter reaches START_TIMEOUT: tx_start=0, set timeout, drop the byte (no retry), go GAP.
  - BUSY: tx_start=0, tx_data held. When tx_active==0, load the gap counter, go GAP.
  - GAP: tx_start=0. After GAP_CYCLES consecutive cycles in GAP, go IDLE. GAP_CYCLES=0 means GAP lasts exactly one cycle.
- Latency: with an empty FIFO in IDLE, a byte written at edge N makes tx_start=1 and tx_data valid from edge N+1.
- Back-to-back frames: tx_start rises no earlier than GAP_CYCLES+2 cycles after the edge at which tx_active is sampled low in BUSY.
- tx_active already high when entering REQ: treated as the start of this frame, so the FSM goes BUSY next edge.
- tx_active glitching high while in IDLE or GAP is ignored.
- empty, full and level reflect the post-edge state of the same clock.

Test Plan:
- Reset then single write 8'hA5: tx_data=8'hA5 and tx_start=1 one cycle after the write edge. Model raises tx_active 3 cycles later: tx_start=0 next edge. tx_active low after 40 cycles: tx_start stays 0 for >=GAP_CYCLES+1 cycles, empty=1.
- Burst of 16 writes (8'h00..8'h0F) with tx_active held low: level reaches 15 (one popped into REQ), full never set. Model then serves frames: bytes appear on tx_data in order 00..0F, each separated by >=2 idle cycles.
- Fill FIFO (DEPTH=16, transmitter stalled in BUSY), then write 8'hFF: full=1, overflow=1, level=16, 8'hFF never transmitted. Pulse clr_flags: overflow=0.
- tx_active never rises with START_TIMEOUT=1023: tx_start falls exactly after the timeout, timeout=1, next queued byte requested after the gap.
- Assert reset low mid-BUSY with 5 bytes queued: tx_start=0, level=0, empty=1 asynchronously. After release, no request is issued until a new write.
- Write and pop in the same cycle with level=16 (IDLE popping while full): the write is rejected and sets overflow, level=15.
